// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit period is BAUD_END clocks, shared with uart_rx.
//
// state    | meaning
// S_IDLE   | line high, ready for a byte
// S_START  | start bit (low)
// S_DATA   | data bits 0..7, LSB first
// S_PARITY | parity bit (skipped when PARITY = 0)
// S_STOP   | STOP_BITS stop bits (high), tx_done in the final cycle
module uart_tx #(
   parameter int BAUD_END  = 5208,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       rs232_tx
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_END - 1);
   localparam logic [15:0] BAUD_PRE  = 16'(BAUD_END - 2);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic        done_q, done_d;
   logic        baud_wrap;

   assign baud_wrap = (baud_q == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // tx_d is the line value for the cycle after the edge, so it follows state_d.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (pi_flag) begin
               shift_d = pi_data;
               par_d   = (PARITY == 1) ? ~^pi_data : ^pi_data;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_wrap) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (baud_wrap) begin
               if (bit_q == 3'd7) begin
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     bit_d   = 3'd0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (baud_wrap) begin
               state_d = S_STOP;
               bit_d   = 3'd0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            // registered pulse: raise it one cycle early so it lands on the last stop cycle
            if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
            if (baud_wrap) begin
               if (bit_q == STOP_LAST) state_d = S_IDLE;
               else                    bit_d   = bit_q + 3'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (state_q == S_IDLE || state_d != state_q || baud_wrap) baud_d = '0;
      else                                                      baud_d = baud_q + 16'd1;
   end

   assign tx_ready = (state_q == S_IDLE);
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_done  = done_q;
   assign rs232_tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity, 1/2 stop bits) under random
// stimulus; accepted bytes are queued and a per-instance monitor checks every line cycle.
module tb_uart_tx;

   typedef struct packed {
      logic [7:0]  d;
      logic [31:0] acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_s = 1'b1;
   int unsigned cyc = 0;
   int          mode = 0;
   logic        check_end = 1'b0;
   logic [2:0]  busy_all;
   int          tests = 0;
   int          fails = 0;
   int          nprint = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rst_s <= rst;
      cyc   <= cyc + 1;
   end

   function automatic int baud_of(int g);
      case (g)
         0: return 8;
         1: return 5;
         default: return 6;
      endcase
   endfunction

   function automatic int par_of(int g);
      return g;
   endfunction

   function automatic int stop_of(int g);
      return (g == 1) ? 2 : 1;
   endfunction

   // bit n of the frame: 0 start, 1..8 data, 9 parity if any, then stop bits
   function automatic logic line_at(logic [7:0] d, int n, int par);
      int ones;
      ones = $countones(d);
      if (n == 0) return 1'b0;
      if (n <= 8) return d[n-1];
      if (par != 0 && n == 9) return (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      return 1'b1;
   endfunction

   task automatic chk(string name, int g, logic [31:0] got, logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         if (nprint < 40) begin
            nprint++;
            $display("FAIL %s inst%0d: got %0h want %0h", name, g, got, want);
         end
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : gen_u
      localparam int B   = baud_of(g);
      localparam int P   = par_of(g);
      localparam int S   = stop_of(g);
      localparam int LEN = B * (9 + ((P != 0) ? 1 : 0) + S);

      logic [7:0] pi_data;
      logic       pi_flag;
      logic       tx_ready, tx_busy, tx_done, rs232_tx;
      exp_t       exp_q[$];

      uart_tx #(.BAUD_END(B), .PARITY(P), .STOP_BITS(S)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .pi_data  (pi_data),
         .pi_flag  (pi_flag),
         .tx_ready (tx_ready),
         .tx_busy  (tx_busy),
         .tx_done  (tx_done),
         .rs232_tx (rs232_tx)
      );

      assign busy_all[g] = tx_busy;

      // driver: inputs change on the falling edge, DUT samples them on the next rising edge
      initial begin
         logic [7:0] dir [3];
         logic [7:0] str [4];
         int didx;
         int sidx;
         dir[0] = 8'hA5; dir[1] = 8'h03; dir[2] = 8'h11;
         str[0] = 8'h00; str[1] = 8'hFF; str[2] = 8'h55; str[3] = 8'hAA;
         didx = 0;
         sidx = 0;
         pi_data = 8'h00;
         pi_flag = 1'b0;
         forever begin
            @(negedge clk);
            pi_data = 8'($urandom);
            case (mode)
               0: pi_flag = 1'b1;
               1: begin
                  if (tx_ready && !rst) begin
                     pi_flag = ($urandom_range(0, 3) == 0);
                     if (pi_flag && didx < 3) begin
                        pi_data = dir[didx];
                        didx++;
                     end
                  end else begin
                     pi_flag = ($urandom_range(0, 19) == 0);
                  end
               end
               2: begin
                  pi_flag = 1'b1;
                  if (tx_ready && !rst && sidx < 4) begin
                     pi_data = str[sidx];
                     sidx++;
                  end
               end
               default: pi_flag = 1'b0;
            endcase
            if (pi_flag && tx_ready && !rst) exp_q.push_back({pi_data, cyc + 1});
         end
      end

      // monitor: reset values, idle values, and every cycle of every frame
      initial begin
         exp_t        cur;
         int          k, ferr, frames, bad_k;
         logic        in_frame, end_valid, prev_stream, end_done;
         int unsigned end_cyc;
         logic [3:0]  got, want, bad_got, bad_want;
         in_frame = 0; end_valid = 0; prev_stream = 0; end_done = 0;
         k = 0; ferr = 0; frames = 0; bad_k = 0; end_cyc = 0;
         cur = '0; bad_got = '0; bad_want = '0;
         forever begin
            @(negedge clk);
            if (rst_s) begin
               chk("rst_line", g, 32'(rs232_tx), 32'd1);
               chk("rst_busy", g, 32'(tx_busy), 32'd0);
               chk("rst_ready", g, 32'(tx_ready), 32'd1);
               chk("rst_done", g, 32'(tx_done), 32'd0);
               in_frame  = 0;
               end_valid = 0;
            end else if (!in_frame && rs232_tx === 1'b1) begin
               chk("idle_ready", g, 32'(tx_ready), 32'd1);
               chk("idle_busy", g, 32'(tx_busy), 32'd0);
               chk("idle_done", g, 32'(tx_done), 32'd0);
            end else begin
               if (!in_frame) begin
                  in_frame = 1;
                  k = 0;
                  ferr = 0;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_frame", g, 32'd1, 32'd0);
                     cur = '0;
                  end else begin
                     cur = exp_q.pop_front();
                     chk("start_latency", g, cyc, cur.acc);
                  end
                  if (mode == 2 && end_valid && prev_stream) chk("stream_gap", g, cyc - end_cyc, 32'd2);
                  prev_stream = (mode == 2);
               end
               got  = {rs232_tx, tx_busy, tx_ready, tx_done};
               want = {line_at(cur.d, k / B, P), 1'b1, 1'b0, (k == LEN - 1)};
               if (got !== want) begin
                  if (ferr == 0) begin
                     bad_k = k;
                     bad_got = got;
                     bad_want = want;
                  end
                  ferr++;
               end
               k++;
               if (k == LEN) begin
                  tests++;
                  if (ferr != 0) begin
                     fails++;
                     if (nprint < 40) begin
                        nprint++;
                        $display("FAIL frame inst%0d byte %02h: %0d bad cycles, first at %0d got line/busy/ready/done %b want %b",
                                 g, cur.d, ferr, bad_k, bad_got, bad_want);
                     end
                  end
                  in_frame  = 0;
                  end_cyc   = cyc;
                  end_valid = 1;
                  frames++;
               end
            end
            if (check_end && !end_done) begin
               end_done = 1;
               chk("queue_empty", g, 32'(exp_q.size()), 32'd0);
               chk("enough_frames", g, 32'(frames >= 10), 32'd1);
            end
         end
      end
   end

   initial begin
      int n;
      rst  = 1'b1;
      mode = 0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      mode = 1;
      repeat (3000) @(posedge clk);

      n = 0;
      while (!busy_all[0] && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("wait_busy", 0, 32'(busy_all[0]), 32'd1);
      repeat (30) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (1500) @(posedge clk);

      #2 mode = 2;
      repeat (2000) @(posedge clk);
      #2 mode = 3;

      n = 0;
      while (busy_all != 3'b000 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 0, 32'(busy_all), 32'd0);
      repeat (5) @(posedge clk);
      check_end = 1'b1;
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
